// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: the core has priority and the host is served on idle cycles.
// A starvation counter forces one host slot after STARVE_LIMIT blocked cycles.
module dm_port_arbiter #(
   parameter int DMA_SIZE     = 16,
   parameter int DMD_SIZE     = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ps_dm_cslt,
   input  logic                ps_dm_wrb,
   input  logic [DMA_SIZE-1:0] dg_dm_add,
   input  logic [DMD_SIZE-1:0] bc_dt,
   output logic                arb_ps_stall,
   input  logic                hst_req,
   input  logic                hst_wrb,
   input  logic [DMA_SIZE-1:0] hst_add,
   input  logic [DMD_SIZE-1:0] hst_wdt,
   output logic                hst_ack,
   output logic [DMD_SIZE-1:0] hst_rdt,
   output logic                hst_rvld,
   output logic                arb_dm_cslt,
   output logic                arb_dm_wrb,
   output logic [DMA_SIZE-1:0] arb_dm_add,
   output logic [DMD_SIZE-1:0] arb_dm_wdt,
   input  logic [DMD_SIZE-1:0] dm_rdt
);

   localparam int CW = 4;

   typedef enum logic [1:0] {GNT_NONE, GNT_CORE, GNT_HOST} gnt_e;

   gnt_e                state_q, state_d;
   logic [CW-1:0]       wait_cnt_q, wait_cnt_d;
   logic [1:0]          rd_tag_q, rd_tag_d;
   logic                cslt_q, cslt_d;
   logic                wrb_q, wrb_d;
   logic [DMA_SIZE-1:0] add_q, add_d;
   logic [DMD_SIZE-1:0] wdt_q, wdt_d;
   logic [DMD_SIZE-1:0] rdt_q, rdt_d;
   logic                rvld_q, rvld_d;
   logic                forced, host_win, core_win;

   always_comb begin
      forced       = hst_req && (wait_cnt_q == CW'(STARVE_LIMIT));
      host_win     = 1'b0;
      core_win     = 1'b0;
      arb_ps_stall = 1'b0;
      if (forced) begin
         host_win     = 1'b1;
         arb_ps_stall = ps_dm_cslt;
      end else if (ps_dm_cslt) begin
         core_win = 1'b1;
      end else if (hst_req) begin
         host_win = 1'b1;
      end
      hst_ack = host_win;

      state_d = GNT_NONE;
      cslt_d  = 1'b0;
      wrb_d   = 1'b0;
      add_d   = add_q;
      wdt_d   = wdt_q;
      if (host_win) begin
         state_d = GNT_HOST;
         cslt_d  = 1'b1;
         wrb_d   = hst_wrb;
         add_d   = hst_add;
         wdt_d   = hst_wdt;
      end else if (core_win) begin
         state_d = GNT_CORE;
         cslt_d  = 1'b1;
         wrb_d   = ps_dm_wrb;
         add_d   = dg_dm_add;
         wdt_d   = bc_dt;
      end

      // Count only cycles where the host is actually waiting; any gap loses the history.
      wait_cnt_d = wait_cnt_q;
      if (!hst_req || hst_ack)
         wait_cnt_d = '0;
      else if (wait_cnt_q != CW'(STARVE_LIMIT))
         wait_cnt_d = wait_cnt_q + CW'(1);

      // Stage 0: host read command on the bus; stage 1: dm_rdt carries its data.
      rd_tag_d[0] = host_win && !hst_wrb;
      rd_tag_d[1] = rd_tag_q[0] && (state_q == GNT_HOST);

      rvld_d = rd_tag_q[1];
      rdt_d  = rd_tag_q[1] ? dm_rdt : rdt_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= GNT_NONE;
         wait_cnt_q <= '0;
         rd_tag_q   <= '0;
         cslt_q     <= 1'b0;
         wrb_q      <= 1'b0;
         add_q      <= '0;
         wdt_q      <= '0;
         rdt_q      <= '0;
         rvld_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         rd_tag_q   <= rd_tag_d;
         cslt_q     <= cslt_d;
         wrb_q      <= wrb_d;
         add_q      <= add_d;
         wdt_q      <= wdt_d;
         rdt_q      <= rdt_d;
         rvld_q     <= rvld_d;
      end
   end

   assign arb_dm_cslt = cslt_q;
   assign arb_dm_wrb  = wrb_q;
   assign arb_dm_add  = add_q;
   assign arb_dm_wdt  = wdt_q;
   assign hst_rdt     = rdt_q;
   assign hst_rvld    = rvld_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Scoreboard bench for dm_port_arbiter: stimulus pushes expected memory commands and
// host read data; a negedge monitor pops and compares whenever the DUT presents them.
module tb_dm_port_arbiter;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ps_dm_cslt = 1'b0, ps_dm_wrb = 1'b0;
   logic [15:0] dg_dm_add = '0, bc_dt = '0;
   logic        arb_ps_stall;
   logic        hst_req = 1'b0, hst_wrb = 1'b0;
   logic [15:0] hst_add = '0, hst_wdt = '0;
   logic        hst_ack;
   logic [15:0] hst_rdt;
   logic        hst_rvld;
   logic        arb_dm_cslt, arb_dm_wrb;
   logic [15:0] arb_dm_add, arb_dm_wdt;
   logic [15:0] dm_rdt = '0;

   int checks = 0;
   int errors = 0;
   logic [32:0] cmd_q[$];
   logic [15:0] rd_q[$];

   dm_port_arbiter #(.DMA_SIZE(16), .DMD_SIZE(16), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .ps_dm_cslt(ps_dm_cslt), .ps_dm_wrb(ps_dm_wrb), .dg_dm_add(dg_dm_add), .bc_dt(bc_dt),
      .arb_ps_stall(arb_ps_stall),
      .hst_req(hst_req), .hst_wrb(hst_wrb), .hst_add(hst_add), .hst_wdt(hst_wdt),
      .hst_ack(hst_ack), .hst_rdt(hst_rdt), .hst_rvld(hst_rvld),
      .arb_dm_cslt(arb_dm_cslt), .arb_dm_wrb(arb_dm_wrb), .arb_dm_add(arb_dm_add),
      .arb_dm_wdt(arb_dm_wdt), .dm_rdt(dm_rdt)
   );

   always #5 clk = ~clk;

   // Memory stand-in: read data appears the cycle after the command (0x0040 -> 0x1234).
   always @(posedge clk)
      if (arb_dm_cslt && !arb_dm_wrb) dm_rdt <= arb_dm_add ^ 16'h1274;

   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every issued command and every read return must match the scoreboard.
   always @(negedge clk) begin
      if (reset && arb_dm_cslt) begin
         if (cmd_q.size() == 0) chk("unexpected_cmd", {arb_dm_wrb, arb_dm_add, arb_dm_wdt}, 33'h0);
         else chk("cmd", {arb_dm_wrb, arb_dm_add, arb_dm_wdt}, cmd_q.pop_front());
      end
      if (reset && hst_rvld) begin
         if (rd_q.size() == 0) chk("unexpected_rvld", {17'h0, hst_rdt}, 33'h0);
         else chk("rdata", {17'h0, hst_rdt}, {17'h0, rd_q.pop_front()});
      end
   end

   // One cycle of stimulus. win: 0 none, 1 core, 2 host.
   task automatic step(input logic c_req, input logic c_wrb, input logic [15:0] c_add,
                       input logic [15:0] c_dt, input logic h_req, input logic h_wrb,
                       input logic [15:0] h_add, input logic [15:0] h_wdt,
                       input logic e_ack, input logic e_stall, input int win,
                       input logic [15:0] e_rd);
      @(posedge clk); #1;
      ps_dm_cslt = c_req; ps_dm_wrb = c_wrb; dg_dm_add = c_add; bc_dt = c_dt;
      hst_req = h_req; hst_wrb = h_wrb; hst_add = h_add; hst_wdt = h_wdt;
      @(negedge clk);
      chk("hst_ack", {32'h0, hst_ack}, {32'h0, e_ack});
      chk("arb_ps_stall", {32'h0, arb_ps_stall}, {32'h0, e_stall});
      if (win == 1) cmd_q.push_back({c_wrb, c_add, c_dt});
      if (win == 2) begin
         cmd_q.push_back({h_wrb, h_add, h_wdt});
         if (!h_wrb) rd_q.push_back(e_rd);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0);
   endtask

   initial begin
      // Reset values
      #12;
      chk("rst_outs", {arb_dm_cslt, arb_dm_wrb, hst_rvld, arb_dm_add, arb_dm_wdt[13:0]}, 33'h0);
      chk("rst_rdt", {17'h0, hst_rdt}, 33'h0);
      @(negedge clk); reset = 1'b1;
      idle(2);

      // Host write with idle core
      step(0, 0, 16'h0, 16'h0, 1, 1, 16'h0012, 16'hBEEF, 1, 0, 2, 16'h0);
      idle(3);

      // Host read: 0x0040 -> 0x1234, single pulse
      step(0, 0, 16'h0, 16'h0, 1, 0, 16'h0040, 16'h0, 1, 0, 2, 16'h1234);
      idle(5);

      // Starvation: core continuous, host blocked 4 cycles then forced
      for (int i = 0; i < 4; i++)
         step(1, 1, 16'h0100 + 16'(i), 16'hA000 + 16'(i), 1, 1, 16'h0099, 16'h5555, 0, 0, 1, 16'h0);
      step(1, 1, 16'h0104, 16'hA004, 1, 1, 16'h0099, 16'h5555, 1, 1, 2, 16'h0);
      step(1, 1, 16'h0104, 16'hA004, 0, 0, 16'h0, 16'h0, 0, 0, 1, 16'h0);
      idle(2);

      // Back-to-back host reads, in order
      step(0, 0, 16'h0, 16'h0, 1, 0, 16'h0001, 16'h0, 1, 0, 2, 16'h1275);
      step(0, 0, 16'h0, 16'h0, 1, 0, 16'h0002, 16'h0, 1, 0, 2, 16'h1276);
      idle(5);

      // Drop after 2 blocked cycles: count restarts, forced after 4 more blocked
      for (int i = 0; i < 2; i++)
         step(1, 0, 16'h0200, 16'h0, 1, 1, 16'h0077, 16'h1111, 0, 0, 1, 16'h0);
      step(1, 0, 16'h0201, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 1, 16'h0);
      for (int i = 0; i < 4; i++)
         step(1, 0, 16'h0210 + 16'(i), 16'h0, 1, 1, 16'h0077, 16'h2222, 0, 0, 1, 16'h0);
      step(1, 0, 16'h0214, 16'h0, 1, 1, 16'h0077, 16'h2222, 1, 1, 2, 16'h0);
      step(1, 0, 16'h0214, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 1, 16'h0);
      idle(5);
      chk("queues_drained", 33'(cmd_q.size() + rd_q.size()), 33'h0);

      // Reset mid-read: ack in N, reset in N+1, no return afterwards
      step(0, 0, 16'h0, 16'h0, 1, 0, 16'h0003, 16'h0, 1, 0, 0, 16'h0);
      @(posedge clk); #1;
      hst_req = 1'b0;
      chk("cmd_before_rst", {32'h0, arb_dm_cslt}, 33'h1);
      #1 reset = 1'b0;
      #1;
      chk("mid_rst_outs", {arb_dm_cslt, arb_dm_wrb, hst_rvld, arb_dm_add, arb_dm_wdt[13:0]}, 33'h0);
      @(negedge clk); reset = 1'b1;
      idle(6);
      chk("post_rst_queues", 33'(cmd_q.size() + rd_q.size()), 33'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
